// File: rtl/trans_pipe.sv
// trans_pipe: multi-lane float-to-fixed remap behind a two-stage valid/ready pipeline.
// Each lane aligns an IEEE-754 single below REF_EXP into a 23-bit field and repacks it under OUT_EXP.
module trans_pipe #(
  parameter int LANES   = 4,
  parameter int REF_EXP = 127,
  parameter int OUT_EXP = 127,
  parameter bit ROUND   = 1'b1,
  parameter bit SAT_EN  = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*LANES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*LANES-1:0] out_data,
  output logic [LANES-1:0]    out_ovf,
  output logic [LANES-1:0]    out_unf,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    ovf_cnt,
  output logic [CNT_W-1:0]    unf_cnt
);

  localparam int          PW    = $clog2(LANES + 1);
  localparam logic [9:0]  REF_W = 10'(REF_EXP);
  localparam logic [7:0]  OEXP  = 8'(OUT_EXP);
  localparam logic [22:0] MAXG  = 23'h7FFFFF;

  function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) begin
      c = c + PW'(v[i]);
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    if (s[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  logic                   v1_r, v2_r;
  logic                   adv1_s, adv2_s;
  logic [LANES-1:0]       sign_s, ovf1_s, unf1_s, guard_s, sticky_s;
  logic [LANES-1:0][22:0] g1_s;
  logic [LANES-1:0]       sign1_r, ovf1_r, unf1_r, guard1_r, sticky1_r;
  logic [LANES-1:0][22:0] g1_r;
  logic [LANES-1:0][31:0] word_s;
  logic [LANES-1:0]       ovf2_s;

  assign adv2_s    = !v2_r || out_ready;
  assign adv1_s    = !v1_r || adv2_s;
  assign in_ready  = adv1_s;
  assign out_valid = v2_r;

  for (genvar i = 0; i < LANES; i++) begin : g_dec
    logic [7:0]  exp_s;
    logic [22:0] man_s;
    logic [23:0] full_s;
    logic [23:0] lo_mask_s;
    logic [9:0]  sh_s;
    logic [4:0]  sa_s;
    logic        sign_l_s, ovf_l_s, unf_l_s, guard_l_s, sticky_l_s;
    logic [22:0] g_l_s;

    assign exp_s  = in_data[32*i+23 +: 8];
    assign man_s  = in_data[32*i +: 23];
    assign full_s = {1'b1, man_s};
    assign sh_s   = REF_W - {2'b00, exp_s};

    // Classify the lane and split {1,m} into kept field, guard bit and sticky bits.
    always_comb begin
      sign_l_s   = in_data[32*i+31];
      ovf_l_s    = 1'b0;
      unf_l_s    = 1'b0;
      guard_l_s  = 1'b0;
      sticky_l_s = 1'b0;
      g_l_s      = 23'd0;
      sa_s       = 5'd0;
      lo_mask_s  = 24'd0;
      if ($signed(sh_s) < 10'sd1) begin
        ovf_l_s = 1'b1;
        g_l_s   = man_s;
      end else if ($signed(sh_s) > 10'sd23) begin
        unf_l_s  = 1'b1;
        sign_l_s = 1'b0;
      end else begin
        sa_s       = sh_s[4:0];
        g_l_s      = 23'(full_s >> sa_s);
        guard_l_s  = full_s[sa_s - 5'd1];
        lo_mask_s  = (24'd1 << (sa_s - 5'd1)) - 24'd1;
        sticky_l_s = |(full_s & lo_mask_s);
      end
    end

    assign sign_s[i]   = sign_l_s;
    assign ovf1_s[i]   = ovf_l_s;
    assign unf1_s[i]   = unf_l_s;
    assign guard_s[i]  = guard_l_s;
    assign sticky_s[i] = sticky_l_s;
    assign g1_s[i]     = g_l_s;
  end

  // Stage 1 register: decoded lanes, held while stage 2 is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r      <= 1'b0;
      sign1_r   <= '0;
      ovf1_r    <= '0;
      unf1_r    <= '0;
      guard1_r  <= '0;
      sticky1_r <= '0;
      g1_r      <= '0;
    end else if (adv1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        sign1_r   <= sign_s;
        ovf1_r    <= ovf1_s;
        unf1_r    <= unf1_s;
        guard1_r  <= guard_s;
        sticky1_r <= sticky_s;
        g1_r      <= g1_s;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    logic        rup_s;
    logic [23:0] sum_s;
    logic [22:0] g_s;
    logic        ovf_s;

    // Nearest-even: round up when above half, or exactly half with an odd kept field.
    assign rup_s = ROUND && guard1_r[i] && (sticky1_r[i] || g1_r[i][0]);
    assign sum_s = {1'b0, g1_r[i]} + {23'd0, rup_s};

    // Apply saturation for out-of-range-high lanes and clamp a rounding carry.
    always_comb begin
      g_s   = sum_s[22:0];
      ovf_s = ovf1_r[i];
      if (ovf1_r[i]) begin
        g_s = SAT_EN ? MAXG : g1_r[i];
      end else if (sum_s[23]) begin
        g_s   = MAXG;
        ovf_s = 1'b1;
      end else begin
        g_s = sum_s[22:0];
      end
    end

    assign word_s[i] = {sign1_r[i], OEXP, g_s};
    assign ovf2_s[i] = ovf_s;
  end

  // Stage 2 register drives the outputs directly; frozen while out_valid & !out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r     <= 1'b0;
      out_data <= '0;
      out_ovf  <= '0;
      out_unf  <= '0;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        out_data <= word_s;
        out_ovf  <= ovf2_s;
        out_unf  <= unf1_r;
      end
    end
  end

  // Range-event counters: count flagged lanes per output transfer, clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
      unf_cnt <= '0;
    end else if (v2_r && out_ready) begin
      ovf_cnt <= sat_add(ovf_cnt, popcnt(out_ovf));
      unf_cnt <= sat_add(unf_cnt, popcnt(out_unf));
    end
  end

endmodule

// File: tb/tb_trans_pipe.sv
// Scoreboard bench for trans_pipe: a default instance and a truncating/non-saturating
// instance share one stimulus stream; expected words are computed from a reference model.
module tb_trans_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         cnt_clr;
  logic         in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [127:0] out_data_a, out_data_b;
  logic [3:0]   out_ovf_a, out_ovf_b, out_unf_a, out_unf_b;
  logic [15:0]  ovf_cnt_a, ovf_cnt_b, unf_cnt_a, unf_cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  int mc_ovf_a = 0, mc_unf_a = 0, mc_ovf_b = 0, mc_unf_b = 0;
  bit rnd_rdy = 1'b0;
  bit stall_a = 1'b0;
  logic [127:0] held_a;
  logic [135:0] qa[$];
  logic [135:0] qb[$];

  trans_pipe dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .out_ovf(out_ovf_a), .out_unf(out_unf_a), .cnt_clr(cnt_clr),
    .ovf_cnt(ovf_cnt_a), .unf_cnt(unf_cnt_a)
  );

  trans_pipe #(.ROUND(1'b0), .SAT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_ovf(out_ovf_b), .out_unf(out_unf_b), .cnt_clr(cnt_clr),
    .ovf_cnt(ovf_cnt_b), .unf_cnt(unf_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference lane: returns {ovf, unf, word}; rounding decided by comparing remainder with half.
  function automatic logic [33:0] model_lane(input logic [31:0] d, input bit rnd, input bit sat);
    int          sh;
    logic [23:0] full, r, half;
    logic [22:0] g;
    logic        s, ovf, unf;
    s    = d[31];
    sh   = 127 - int'(d[30:23]);
    full = {1'b1, d[22:0]};
    ovf  = 1'b0;
    unf  = 1'b0;
    g    = 23'd0;
    if (sh < 1) begin
      ovf = 1'b1;
      g   = sat ? 23'h7FFFFF : d[22:0];
    end else if (sh > 23) begin
      unf = 1'b1;
      s   = 1'b0;
    end else begin
      g    = 23'(full >> sh);
      r    = full & ((24'd1 << sh) - 24'd1);
      half = 24'd1 << (sh - 1);
      if (rnd && (r > half || (r == half && g[0]))) begin
        if (g == 23'h7FFFFF) ovf = 1'b1;
        else g = g + 23'd1;
      end
    end
    return {ovf, unf, s, 8'd127, g};
  endfunction

  function automatic logic [135:0] model_group(input logic [127:0] d, input bit rnd, input bit sat);
    logic [33:0]  l;
    logic [135:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      l = model_lane(d[32*i +: 32], rnd, sat);
      res[32*i +: 32] = l[31:0];
      res[128 + i]    = l[32];
      res[132 + i]    = l[33];
    end
    return res;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic logic [31:0] rnd_lane();
    logic [7:0] e;
    e = 8'($urandom_range(98, 130));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // Random backpressure source, active only while rnd_rdy is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor: sampled on the falling edge, ahead of the next active edge.
  initial begin
    logic [135:0] e;
    logic         exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_rdy = !(qa.size() == 2 && !out_ready);
        check("in_ready_a", in_ready_a, exp_rdy);
        check("in_ready_b", in_ready_b, exp_rdy);
        if (stall_a) begin
          check("hold_valid", out_valid_a, 1'b1);
          check("hold_data", out_data_a, held_a);
        end
        stall_a = out_valid_a && !out_ready;
        held_a  = out_data_a;
        check("ovf_cnt_a", ovf_cnt_a, mc_ovf_a);
        check("unf_cnt_a", unf_cnt_a, mc_unf_a);
        check("ovf_cnt_b", ovf_cnt_b, mc_ovf_b);
        check("unf_cnt_b", unf_cnt_b, mc_unf_b);
        if (out_valid_a && out_ready) begin
          if (qa.size() == 0) begin
            check("unexpected_out_a", 1'b1, 1'b0);
          end else begin
            e = qa.pop_front();
            check("data_a", out_data_a, e[127:0]);
            check("unf_a", out_unf_a, e[131:128]);
            check("ovf_a", out_ovf_a, e[135:132]);
            mc_ovf_a = sat16(mc_ovf_a + $countones(e[135:132]));
            mc_unf_a = sat16(mc_unf_a + $countones(e[131:128]));
            n_out++;
          end
        end
        if (out_valid_b && out_ready) begin
          if (qb.size() == 0) begin
            check("unexpected_out_b", 1'b1, 1'b0);
          end else begin
            e = qb.pop_front();
            check("data_b", out_data_b, e[127:0]);
            check("unf_b", out_unf_b, e[131:128]);
            check("ovf_b", out_ovf_b, e[135:132]);
            mc_ovf_b = sat16(mc_ovf_b + $countones(e[135:132]));
            mc_unf_b = sat16(mc_unf_b + $countones(e[131:128]));
          end
        end
        if (cnt_clr) begin
          mc_ovf_a = 0; mc_unf_a = 0; mc_ovf_b = 0; mc_unf_b = 0;
        end
        if (in_valid && in_ready_a) begin
          qa.push_back(model_group(in_data, 1'b1, 1'b1));
          qb.push_back(model_group(in_data, 1'b0, 1'b0));
        end
      end
    end
  end

  // Present a group from posedge+1 and hold it until accepted.
  task automatic send(input logic [127:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) check("send_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int k);
    k = 0;
    @(negedge clk);
    while (!out_valid_a && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (qa.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", qa.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Single G0 group from an idle pipe: latency, packed words and unf counting.
  task automatic latency_g0();
    int k;
    send(128'hBF000000_00000000_3E800000_3F000000);
    wait_out(k);
    check("latency", k + 1, 2);
    check("g0_data", out_data_a, 128'hBFC00000_3F800000_3FA00000_3FC00000);
    check("g0_unf", out_unf_a, 4'b0100);
    check("g0_ovf", out_ovf_a, 4'b0000);
    @(negedge clk);
    check("g0_unf_cnt", unf_cnt_a, 16'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    #1;
    check("rst_out_valid", out_valid_a, 1'b0);
    check("rst_out_data", out_data_a, 128'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_ovf_cnt", ovf_cnt_a, 16'd0);
    @(posedge clk);
    #1;

    latency_g0();

    send(128'h7FC00000_3F7FFFFF_3F000003_3F800000);
    wait_out(k);
    check("g1_data_a", out_data_a, 128'h3FFFFFFF_3FFFFFFF_3FC00002_3FFFFFFF);
    check("g1_ovf_a", out_ovf_a, 4'b1101);
    check("g1_data_b", out_data_b, 128'h3FC00000_3FFFFFFF_3FC00001_3F800000);
    check("g1_ovf_b", out_ovf_b, 4'b1001);
    drain();

    n0 = n_out;
    rnd_rdy = 1'b1;
    send(128'hB4000000_33FFFFFF_34400000_FF800000);
    for (int i = 0; i < 9; i++) send({rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()});
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp_count", n_out - n0, 10);

    out_ready = 1'b0;
    send(128'h3F000000_3F000000_3F800000_3F800000);
    send(128'h00000000_3E800000_3F800000_3F000000);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid_a, 1'b0);
    check("arst_out_data", out_data_a, 128'd0);
    check("arst_ovf_cnt", ovf_cnt_a, 16'd0);
    check("arst_unf_cnt", unf_cnt_a, 16'd0);
    qa.delete(); qb.delete();
    mc_ovf_a = 0; mc_unf_a = 0; mc_ovf_b = 0; mc_unf_b = 0;
    stall_a = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    latency_g0();
    drain();

    for (int i = 0; i < 16385; i++) send({4{32'h3F800000}});
    drain();
    check("ovf_sat_a", ovf_cnt_a, 16'hFFFF);
    check("ovf_sat_b", ovf_cnt_b, 16'hFFFF);

    out_ready = 1'b0;
    send({4{32'h3F800000}});
    wait_out(k);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_ovf_a", ovf_cnt_a, 16'd0);
    check("clr_ovf_b", ovf_cnt_b, 16'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
